// File: rtl/proj_param_pkg.sv
// Project-wide parameters shared by blocks that size themselves to the GPIO bank.
package proj_param_pkg;

    localparam int PROJ_GPIO = 32;

endpackage

// File: rtl/verilab_core_gpio_irq.sv
// GPIO input conditioner: per-bit synchroniser, debounce filter, edge detect
// under programmable rise/fall mode, sticky W1C status and a masked,
// registered interrupt output.
module verilab_core_gpio_irq #(
    parameter int GPIO        = proj_param_pkg::PROJ_GPIO,
    parameter int DEBOUNCE_W  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [GPIO-1:0]       gpio_in,
    input  logic [DEBOUNCE_W-1:0] deb_limit,
    input  logic [GPIO-1:0]       mode_rise,
    input  logic [GPIO-1:0]       mode_fall,
    input  logic [GPIO-1:0]       irq_en,
    input  logic [GPIO-1:0]       clr,
    output logic [GPIO-1:0]       gpio_val,
    output logic [GPIO-1:0]       irq_status,
    output logic                  irq
);

    logic [GPIO-1:0] sync_bit;
    logic [GPIO-1:0] update;
    logic [GPIO-1:0] ev;
    logic [GPIO-1:0] gpio_val_reg;
    logic [GPIO-1:0] irq_status_reg;
    logic [GPIO-1:0] irq_status_next;
    logic            irq_reg;
    logic            irq_next;

    generate
        for (genvar gi = 0; gi < GPIO; gi++) begin : g_bit
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [DEBOUNCE_W-1:0]  cnt_reg;
            logic [DEBOUNCE_W-1:0]  cnt_next;
            logic                   mismatch;

            // Shift the raw pad bit through the synchroniser chain.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], gpio_in[gi]};
                end
            end

            assign sync_bit[gi] = sync_reg[SYNC_STAGES-1];
            assign mismatch     = sync_bit[gi] != gpio_val_reg[gi];
            // The >= compare lets a lowered limit take effect on the next
            // mismatching cycle and keeps the counter from ever wrapping.
            assign update[gi]   = mismatch && (cnt_reg >= deb_limit);

            // Count consecutive mismatching cycles; restart on match or on update.
            always_comb begin
                cnt_next = cnt_reg + 1'b1;
                if (!mismatch || update[gi]) begin
                    cnt_next = '0;
                end
            end

            // Debounce counter register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

    // An update always moves gpio_val toward sync, so the new value is sync itself.
    assign ev = (update &  sync_bit & mode_rise) |
                (update & ~sync_bit & mode_fall);

    // Next status and interrupt: a new event wins over a same-cycle clear, and
    // irq follows the next status so both change on the same edge.
    always_comb begin
        irq_status_next = (irq_status_reg & ~clr) | ev;
        irq_next        = |(irq_status_next & irq_en);
    end

    // Debounced value, sticky status and interrupt registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_val_reg   <= '0;
            irq_status_reg <= '0;
            irq_reg        <= 1'b0;
        end else begin
            gpio_val_reg   <= gpio_val_reg ^ update;
            irq_status_reg <= irq_status_next;
            irq_reg        <= irq_next;
        end
    end

    assign gpio_val   = gpio_val_reg;
    assign irq_status = irq_status_reg;
    assign irq        = irq_reg;

endmodule

// File: tb/tb_verilab_core_gpio_irq.sv
// Self-checking bench for verilab_core_gpio_irq: directed scenarios plus a
// randomized run compared against a run-length reference model.
module tb_verilab_core_gpio_irq;

    localparam int GPIO = 32;
    localparam int DW   = 4;
    localparam int SS   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [GPIO-1:0] gpio_in;
    logic [DW-1:0]   deb_limit;
    logic [GPIO-1:0] mode_rise;
    logic [GPIO-1:0] mode_fall;
    logic [GPIO-1:0] irq_en;
    logic [GPIO-1:0] clr;
    logic [GPIO-1:0] gpio_val;
    logic [GPIO-1:0] irq_status;
    logic            irq;

    int errors = 0;
    int checks = 0;

    // Reference model state: input sample history, per-bit mismatch run length.
    logic [GPIO-1:0] m_hist[$];
    logic [GPIO-1:0] m_val;
    logic [GPIO-1:0] m_status;
    logic            m_irq;
    int              m_run[GPIO];

    verilab_core_gpio_irq #(
        .GPIO       (GPIO),
        .DEBOUNCE_W (DW),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gpio_in   (gpio_in),
        .deb_limit (deb_limit),
        .mode_rise (mode_rise),
        .mode_fall (mode_fall),
        .irq_en    (irq_en),
        .clr       (clr),
        .gpio_val  (gpio_val),
        .irq_status(irq_status),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_hist = {};
        for (int k = 0; k < SS; k++) m_hist.push_back('0);
        m_val    = '0;
        m_status = '0;
        m_irq    = 1'b0;
        for (int i = 0; i < GPIO; i++) m_run[i] = 0;
    endtask

    // Advance one clock edge and update the model from the inputs seen at that
    // edge; a bit changes once its synchronised value has disagreed with the
    // debounced value for deb_limit+1 consecutive edges.
    task automatic step();
        logic [GPIO-1:0] s;
        logic [GPIO-1:0] evm;
        @(posedge clk);
        s   = m_hist[0];
        evm = '0;
        for (int i = 0; i < GPIO; i++) begin
            if (s[i] != m_val[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] > int'(deb_limit)) begin
                    m_val[i] = s[i];
                    m_run[i] = 0;
                    if (s[i] ? mode_rise[i] : mode_fall[i]) evm[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_status = (m_status & ~clr) | evm;
        m_irq    = |(m_status & irq_en);
        void'(m_hist.pop_front());
        m_hist.push_back(gpio_in);
        #1;
    endtask

    task automatic apply_reset(input logic [GPIO-1:0] in_val);
        gpio_in = in_val;
        rst     = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clr = '0; mode_rise = '1; mode_fall = '1; irq_en = '1; deb_limit = 4'd0;
        apply_reset('0);
        gpio_in = 32'h0000_00FF;
        repeat (4) step();
        deb_limit = 4'd15;
        gpio_in   = '0;
        repeat (5) step();
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({gpio_val, irq_status, irq} !== '0) begin
            errors++;
            $display("FAIL reset_async: got val=%h st=%h irq=%b want all 0", gpio_val, irq_status, irq);
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if ({gpio_val, irq_status, irq} !== '0) begin
                errors++;
                $display("FAIL reset_hold c=%0d: got val=%h st=%h irq=%b want all 0", c, gpio_val, irq_status, irq);
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_basic_rise();
        clr = '0; mode_rise = 32'h1; mode_fall = '0; irq_en = 32'h1; deb_limit = 4'd3;
        apply_reset('0);
        gpio_in[0] = 1'b1;
        repeat (5) step();
        checks++;
        if ({gpio_val[0], irq_status, irq} !== '0) begin
            errors++;
            $display("FAIL rise_e5: got val0=%b st=%h irq=%b want 0/0/0", gpio_val[0], irq_status, irq);
        end
        step();
        checks++;
        if (gpio_val[0] !== 1'b1 || irq_status !== 32'h1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL rise_e6: got val0=%b st=%h irq=%b want 1/00000001/1", gpio_val[0], irq_status, irq);
        end
        $display("test_basic_rise: done");
    endtask

    task automatic test_glitch();
        clr = '0; mode_rise = '1; mode_fall = '1; irq_en = '1; deb_limit = 4'd3;
        apply_reset('0);
        gpio_in[1] = 1'b1;
        repeat (3) step();
        gpio_in[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (gpio_val[1] !== 1'b0 || irq_status !== '0) begin
                errors++;
                $display("FAIL glitch c=%0d: got val1=%b st=%h want 0/0", c, gpio_val[1], irq_status);
            end
        end
        $display("test_glitch: done");
    endtask

    task automatic test_fall_mask();
        clr = '0; mode_rise = '0; mode_fall = 32'h4; irq_en = '0; deb_limit = 4'd0;
        apply_reset('0);
        gpio_in[2] = 1'b1;
        repeat (3) step();
        checks++;
        if (gpio_val[2] !== 1'b1 || irq_status !== '0) begin
            errors++;
            $display("FAIL fall_rise_ignored: got val2=%b st=%h want 1/0", gpio_val[2], irq_status);
        end
        gpio_in[2] = 1'b0;
        repeat (3) step();
        checks++;
        if (gpio_val[2] !== 1'b0 || irq_status !== 32'h4 || irq !== 1'b0) begin
            errors++;
            $display("FAIL fall_set: got val2=%b st=%h irq=%b want 0/00000004/0", gpio_val[2], irq_status, irq);
        end
        irq_en = 32'h4;
        step();
        checks++;
        if (irq !== 1'b1 || irq_status !== 32'h4) begin
            errors++;
            $display("FAIL fall_unmask: got irq=%b st=%h want 1/00000004", irq, irq_status);
        end
        $display("test_fall_mask: done");
    endtask

    task automatic test_collision();
        clr = '0; mode_rise = 32'h8; mode_fall = '0; irq_en = 32'h8; deb_limit = 4'd0;
        apply_reset('0);
        gpio_in[3] = 1'b1;
        repeat (3) step();
        gpio_in[3] = 1'b0;
        repeat (3) step();
        checks++;
        if (irq_status !== 32'h8 || irq !== 1'b1) begin
            errors++;
            $display("FAIL coll_first: got st=%h irq=%b want 00000008/1", irq_status, irq);
        end
        gpio_in[3] = 1'b1;
        repeat (2) step();
        clr = 32'h8;
        step();
        checks++;
        if (irq_status[3] !== 1'b1 || irq !== 1'b1 || gpio_val[3] !== 1'b1) begin
            errors++;
            $display("FAIL coll_set_wins: got st3=%b irq=%b val3=%b want 1/1/1", irq_status[3], irq, gpio_val[3]);
        end
        step();
        clr = '0;
        checks++;
        if (irq_status !== '0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL coll_clear: got st=%h irq=%b want 0/0", irq_status, irq);
        end
        $display("test_collision: done");
    endtask

    task automatic test_multibit_reset();
        clr = '0; mode_rise = '1; mode_fall = '0; irq_en = '0; deb_limit = 4'd0;
        apply_reset(32'hFFFF_0000);
        repeat (2) step();
        checks++;
        if (irq_status !== '0) begin
            errors++;
            $display("FAIL multi_e2: got st=%h want 00000000", irq_status);
        end
        step();
        checks++;
        if (irq_status !== 32'hFFFF_0000 || gpio_val !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL multi_e3: got st=%h val=%h want ffff0000/ffff0000", irq_status, gpio_val);
        end
        $display("test_multibit_reset: done");
    endtask

    task automatic test_random();
        int blk_err;
        clr = '0; deb_limit = 4'($urandom_range(0, 3));
        mode_rise = $urandom; mode_fall = $urandom; irq_en = $urandom;
        apply_reset($urandom);
        for (int blk = 0; blk < 50; blk++) begin
            blk_err = 0;
            if (blk == 25) apply_reset($urandom);
            if ($urandom_range(0, 4) == 0) deb_limit = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) irq_en = $urandom;
            for (int c = 0; c < 8; c++) begin
                gpio_in = gpio_in ^ ($urandom & $urandom & $urandom);
                clr     = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom) : '0;
                step();
                checks++;
                if (gpio_val !== m_val || irq_status !== m_status || irq !== m_irq) begin
                    errors++;
                    blk_err++;
                    $display("FAIL rand blk=%0d c=%0d: got val=%h st=%h irq=%b want val=%h st=%h irq=%b",
                             blk, c, gpio_val, irq_status, irq, m_val, m_status, m_irq);
                end
            end
            clr = '0;
            $display("rand blk=%0d lim=%0d in=%h val=%h st=%h irq=%b errs=%0d",
                     blk, deb_limit, gpio_in, gpio_val, irq_status, irq, blk_err);
        end
    endtask

    initial begin
        rst = 1'b1; gpio_in = '0; deb_limit = '0;
        mode_rise = '0; mode_fall = '0; irq_en = '0; clr = '0;
        model_reset();
        test_reset();
        test_basic_rise();
        test_glitch();
        test_fall_mask();
        test_collision();
        test_multibit_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/verilab_core_gpio_irq.md
# verilab_core_gpio_irq

Parametrised GPIO input conditioner that takes asynchronous pad-side `gpio_in` bits, synchronises and debounces each bit independently, detects rising/falling edges per bit under programmable mode, and records them in sticky write-1-to-clear interrupt status with a masked, registered interrupt output. It sits between the pad ring and the register/interrupt fabric. It is the first sequential consumer of the project-wide GPIO width, generalising fixed-width GPIO handling with per-bit debounce and edge-mode interrupts.

## Interface

**Parameters**
- `GPIO`, default `proj_param_pkg::PROJ_GPIO`: number of GPIO bits (1..64).
- `DEBOUNCE_W`, default 4: width of debounce counter and `deb_limit`.
- `SYNC_STAGES`, default 2: synchroniser flop depth (≥2).

**Ports**
- `clk`, input, 1: sole clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `gpio_in`, input, GPIO: raw asynchronous inputs.
- `deb_limit`, input, DEBOUNCE_W: stable-cycle threshold shared by all bits; quasi-static.
- `mode_rise`, input, GPIO: per-bit enable for recording rising edges.
- `mode_fall`, input, GPIO: per-bit enable for recording falling edges.
- `irq_en`, input, GPIO: per-bit interrupt mask (1 = enabled).
- `clr`, input, GPIO: per-bit write-1-to-clear pulse for `irq_status`.
- `gpio_val`, output, GPIO: debounced value.
- `irq_status`, output, GPIO: sticky edge status.
- `irq`, output, 1: registered OR of `irq_status & irq_en`.

## Operation

- **Reset values.** Asserting `rst` clears all of the following immediately, with no clock needed:
  - synchroniser flops, debounce counters, `gpio_val`, `irq_status` and `irq` all go to 0.
- **Synchroniser.** Per bit, a chain of `SYNC_STAGES` flops is clocked by `clk`. `sync[i]` is the last stage.
- **Debounce.** Per bit, evaluated every cycle:
  - If `sync[i] == gpio_val[i]`: `cnt[i] <= 0`.
  - Else, if `cnt[i] >= deb_limit`: `gpio_val[i] <= sync[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i] + 1`.
  - An update therefore requires `deb_limit+1` consecutive mismatching cycles.
  - `deb_limit = 0` gives a one-cycle follow.
  - The `>=` compare means lowering `deb_limit` mid-count updates on the next mismatching cycle.
  - The counter never exceeds `deb_limit`, so no wrap is possible.
- **Edge events.** Computed combinationally from the debounce update condition, on the same edge that `gpio_val` updates:
  - `rise[i]` = update && `sync[i]==1`.
  - `fall[i]` = update && `sync[i]==0`.
  - `ev[i]` = (`rise[i]` & `mode_rise[i]`) | (`fall[i]` & `mode_fall[i]`).
- **Status.** `irq_status <= (irq_status & ~clr) | ev`.
  - Set wins over a simultaneous clear of the same bit.
  - `clr` on a bit that is already 0 has no effect.
  - Status records events regardless of `irq_en`.
- **Interrupt.** `irq <= |(next_irq_status & irq_en)`.
  - Changing `irq_en` alone affects `irq` one edge later.
- **Mid-operation reset.** All in-progress counts are discarded; every bit restarts from `gpio_val = 0`.
- **Inputs high at reset release.** A `gpio_in` bit held high while `rst` deasserts produces a rising event after the normal latency. Software masks or clears this event.

## Timing

- Let `gpio_in[i]` change and settle before clock edge E1.
- `sync[i]` reflects the change after edge E`SYNC_STAGES`.
- `gpio_val[i]` and `irq_status[i]` update at edge E(`SYNC_STAGES` + `deb_limit` + 1).
- `irq` updates at that same edge, because it is driven from the next-state of `irq_status`.
- With defaults and `deb_limit = 0`: `gpio_val`, status and `irq` all change at E3.
- A `clr` sampled at edge E drops `irq_status` and `irq` at E, unless a new event sets the bit at E.
- Glitches shorter than `deb_limit+1` cycles at the synchroniser output never reach `gpio_val`.
- Throughput: one event per bit per `deb_limit+1` cycles at most.

## Test plan

- **Reset state.** Assert `rst` mid-count, then release with `gpio_in = 0`. All outputs are 0, and stay 0 for 20 cycles.
- **Basic rise.** `GPIO = 8`, `deb_limit = 3`, `mode_rise = 8'h01`, `irq_en = 8'h01`. Raise `gpio_in[0]` before E1.
  - `gpio_val[0]` = 1, `irq_status[0]` = 1 and `irq` = 1 at E6.
  - No change at E5.
- **Glitch reject.** `deb_limit = 3`. Pulse `gpio_in[1]` high for 3 cycles, then return low.
  - `gpio_val[1]` stays 0.
  - `irq_status` stays 8'h00.
- **Fall-only and mask.**
  - `mode_fall[2] = 1`, `mode_rise[2] = 0`, `irq_en[2] = 0`.
  - Drive bit 2 high then low with `deb_limit = 0`.
  - Only the falling edge sets `irq_status[2]`, and `irq` stays 0.
  - Setting `irq_en[2] = 1` asserts `irq` one edge later.
- **Set/clear collision.**
  - Pulse `clr[3]` on the same edge that a new rising event on bit 3 is recorded: `irq_status[3]` stays 1.
  - `clr[3]` one edge later clears it, and `irq` drops on that same edge.
- **Multi-bit plus high at reset.**
  - `GPIO = 32`, `gpio_in = 32'hFFFF_0000` held through reset release, `mode_rise` all ones, `deb_limit = 0`.
  - `irq_status = 32'hFFFF_0000` at E3 after release.
